// File: rtl/operacion_pkg.sv
// rtl/operacion_pkg.sv - shared types and constants for the BCD-entry sequential divider
package operacion_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;
    localparam logic [3:0] TENS_ONE  = 4'h1;
    localparam logic [3:0] TEN       = 4'd10;
    localparam logic [2:0] ITER      = 3'd4;

endpackage

// File: rtl/operacion_if.sv
// rtl/operacion_if.sv - operand entry / result bundle between keypad logic and divider
interface operacion_if;
    logic       start;
    logic [7:0] a_bcd;
    logic [7:0] b_bcd;
    logic [3:0] cociente;
    logic [3:0] resto;

    modport master (
        output start, a_bcd, b_bcd,
        input  cociente, resto
    );

    modport slave (
        input  start, a_bcd, b_bcd,
        output cociente, resto
    );
endinterface

// File: rtl/operacion_bcd2bin.sv
// rtl/operacion_bcd2bin.sv - two-digit keypad entry {tens, units} to 4-bit binary
module bcd2bin
    import operacion_pkg::*;
(
    input  logic [7:0] bcd,
    output logic [3:0] bin
);

    logic [3:0] tens_val;
    logic [3:0] units_val;

    assign tens_val  = (bcd[7:4] == TENS_ONE)  ? TEN : 4'd0;
    // A blank units digit (not keyed) counts as zero; the sum wraps mod 16.
    assign units_val = (bcd[3:0] != BCD_BLANK) ? bcd[3:0] : 4'd0;
    assign bin       = tens_val + units_val;

endmodule

// File: rtl/operacion.sv
// rtl/operacion.sv - restoring 4-bit divider, one quotient bit per clock
module operacion
    import operacion_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    operacion_if.slave  bus
);

    state_t     state;
    logic [3:0] a_bin;
    logic [3:0] b_bin;
    logic [3:0] a_lat;
    logic [3:0] b_lat;
    logic [4:0] r;
    logic [3:0] q;
    logic [3:0] d;
    logic [2:0] count;
    logic [3:0] cociente_q;
    logic [3:0] resto_q;

    logic [5:0] trial;
    logic [4:0] r_next;
    logic [3:0] q_next;

    bcd2bin u_a_conv (.bcd(bus.a_bcd), .bin(a_bin));
    bcd2bin u_b_conv (.bcd(bus.b_bcd), .bin(b_bin));

    // With D=0 every trial succeeds, so Q fills with ones and R collects A.
    always_comb begin
        trial  = {r, q[3]};
        r_next = trial[4:0];
        q_next = {q[2:0], 1'b0};
        if (trial >= {2'b00, d}) begin
            r_next = 5'(trial - {2'b00, d});
            q_next = {q[2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            a_lat      <= '0;
            b_lat      <= '0;
            r          <= '0;
            q          <= '0;
            d          <= '0;
            count      <= '0;
            cociente_q <= '0;
            resto_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        a_lat <= a_bin;
                        b_lat <= b_bin;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    r     <= '0;
                    q     <= a_lat;
                    d     <= b_lat;
                    count <= ITER;
                    state <= RUN;
                end
                RUN: begin
                    r     <= r_next;
                    q     <= q_next;
                    count <= count - 3'd1;
                    if (count == 3'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    cociente_q <= q;
                    resto_q    <= r[3:0];
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cociente = cociente_q;
    assign bus.resto    = resto_q;

endmodule

// File: tb/tb_operacion.sv
// tb/tb_operacion.sv - scoreboard bench for the operacion divider
module tb_operacion;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    operacion_if bus ();

    operacion dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] sb[$];
    logic [7:0] last = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got q=%0d r=%0d expected q=%0d r=%0d",
                     tag, obs[7:4], obs[3:0], exp[7:4], exp[3:0]);
        end
    endtask

    function automatic logic [3:0] to_bin(input logic [7:0] v);
        logic [3:0] t;
        logic [3:0] u;
        t = (v[7:4] == 4'h1) ? 4'd10 : 4'd0;
        u = (v[3:0] == 4'hF) ? 4'd0 : v[3:0];
        return t + u;
    endfunction

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b);
        logic [3:0] av;
        logic [3:0] bv;
        av = to_bin(a);
        bv = to_bin(b);
        if (bv == 4'd0) return {4'hF, av};
        return {av / bv, av % bv};
    endfunction

    function automatic logic [7:0] outs();
        return {bus.cociente, bus.resto};
    endfunction

    task automatic pop_check(input string tag);
        logic [7:0] exp;
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, outs(), ~outs());
        end else begin
            exp = sb.pop_front();
            check(tag, outs(), exp);
            last = exp;
        end
    endtask

    // Operands are scrambled right after acceptance: the result must use the latched values.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input string tag);
        @(negedge clk);
        bus.a_bcd = a;
        bus.b_bcd = b;
        bus.start = 1'b1;
        sb.push_back(model(a, b));
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a_bcd = 8'($urandom);
        bus.b_bcd = 8'($urandom);
        repeat (5) @(posedge clk);
        #1 check({tag, "_hold"}, outs(), last);
        @(posedge clk);
        #1 pop_check(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        bus.start = 1'b0;
        bus.a_bcd = 8'h00;
        bus.b_bcd = 8'h00;
        repeat (3) @(posedge clk);
        #1 check("reset", outs(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        run_op(8'h04, 8'h02, "4_div_2");
        run_op(8'h09, 8'h03, "9_div_3");
        run_op(8'h12, 8'h04, "12_div_4");
        run_op(8'h15, 8'h06, "15_div_6");
        run_op(8'h0F, 8'h05, "blank_units");
        run_op(8'h07, 8'h00, "div_zero");
        run_op(8'h1F, 8'h03, "tens_blank");
        run_op(8'h25, 8'h01, "bad_tens");

        for (int i = 0; i < 12; i++) begin
            ra = {($urandom_range(0, 1) == 0) ? 4'h1 : 4'($urandom), 4'($urandom)};
            rb = {($urandom_range(0, 1) == 0) ? 4'h1 : 4'($urandom), 4'($urandom)};
            run_op(ra, rb, "random");
        end

        // A second start during RUN must be ignored.
        @(negedge clk);
        bus.a_bcd = 8'h15;
        bus.b_bcd = 8'h04;
        bus.start = 1'b1;
        sb.push_back(model(8'h15, 8'h04));
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.a_bcd = 8'h09;
        bus.b_bcd = 8'h03;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("ignored_start_hold", outs(), last);
        @(posedge clk);
        #1 pop_check("ignored_start");
        check("ignored_start_val", outs(), 8'h33);
        repeat (7) @(posedge clk);
        #1 check("no_extra_result", outs(), last);

        // Start held high: re-accept on the edge after DONE with the then-current operands.
        @(negedge clk);
        bus.a_bcd = 8'h14;
        bus.b_bcd = 8'h03;
        bus.start = 1'b1;
        sb.push_back(model(8'h14, 8'h03));
        @(posedge clk);
        #1;
        bus.a_bcd = 8'h11;
        bus.b_bcd = 8'h02;
        sb.push_back(model(8'h11, 8'h02));
        repeat (5) @(posedge clk);
        #1 check("held_first_hold", outs(), last);
        @(posedge clk);
        #1 pop_check("held_first");
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (5) @(posedge clk);
        #1 check("held_second_hold", outs(), last);
        @(posedge clk);
        #1 pop_check("held_second");

        // Asynchronous reset mid-division aborts the operation.
        @(negedge clk);
        bus.a_bcd = 8'h15;
        bus.b_bcd = 8'h04;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1 check("async_reset", outs(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(posedge clk);
        #1 check("aborted_no_result", outs(), 8'h00);
        last = 8'h00;
        run_op(8'h13, 8'h05, "after_reset");
        check("after_reset_val", outs(), 8'h23);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
